// File: rtl/led_pwm_if.sv
// Avalon-MM slave bundle for the LED PWM driver.
// Master side drives the bus; slave side returns readdata.
interface led_pwm_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/led_pwm_driver.sv
// Four-channel LED PWM driver with frame-synchronous duty update
// and per-channel blink gating, behind an Avalon-MM register slave.
module led_pwm_driver #(
  parameter int unsigned PRESCALE = 50
) (
  input  logic        clk,
  input  logic        reset,
  led_pwm_if.slave    bus,
  input  logic [3:0]  led_in,
  output logic [3:0]  led_out
);

  localparam logic [1:0] A_BRIGHT = 2'd0;
  localparam logic [1:0] A_BLINK  = 2'd1;
  localparam logic [1:0] A_HALF   = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;

  localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);
  localparam logic [15:0] HALF_RST = 16'd100;

  logic [15:0] presc_q, presc_d;
  logic [7:0]  pwm_cnt_q, pwm_cnt_d;
  logic [31:0] bright_next_q, bright_next_d;
  logic [31:0] duty_q, duty_d;
  logic [3:0]  blink_en_q, blink_en_d;
  logic [15:0] blink_half_q, blink_half_d;
  logic [15:0] frame_q, frame_d;
  logic        phase_q, phase_d;
  logic [3:0]  led_out_q, led_out_d;

  logic        wr_en;
  logic        tick;
  logic        frame_end;
  logic [15:0] half_last;
  logic [3:0]  pwm_on;
  logic [7:0]  duty_ch;

  assign wr_en     = bus.chipselect & ~bus.write_n;
  assign tick      = (presc_q == PS_LAST);
  assign frame_end = tick & (pwm_cnt_q == 8'hFF);

  // A half-period of 0 behaves as 1: toggle every frame.
  assign half_last = (blink_half_q == 16'd0) ? 16'd0
                                             : blink_half_q - 16'd1;

  always_comb begin
    presc_d   = tick ? 16'd0 : presc_q + 16'd1;
    pwm_cnt_d = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
  end

  always_comb begin
    bright_next_d = bright_next_q;
    blink_en_d    = blink_en_q;
    blink_half_d  = blink_half_q;
    if (wr_en) begin
      unique case (bus.address)
        A_BRIGHT: bright_next_d = bus.writedata;
        A_BLINK:  blink_en_d    = bus.writedata[3:0];
        A_HALF:   blink_half_d  = bus.writedata[15:0];
        A_STATUS: ;
      endcase
    end
  end

  // Duty only moves at frame end, from the value held before any
  // same-cycle write, so a frame never mixes two duty settings.
  always_comb begin
    duty_d  = duty_q;
    frame_d = frame_q;
    phase_d = phase_q;
    if (frame_end) begin
      duty_d = bright_next_q;
      if (frame_q >= half_last) begin
        frame_d = 16'd0;
        phase_d = ~phase_q;
      end else begin
        frame_d = frame_q + 16'd1;
      end
    end
  end

  always_comb begin
    pwm_on  = 4'd0;
    duty_ch = 8'd0;
    for (int i = 0; i < 4; i++) begin
      duty_ch   = duty_q[8*i +: 8];
      pwm_on[i] = (duty_ch == 8'hFF) | (pwm_cnt_q < duty_ch);
    end
  end

  always_comb begin
    led_out_d = led_in & pwm_on & (~blink_en_q | {4{phase_q}});
  end

  always_comb begin
    bus.readdata = 32'd0;
    unique case (bus.address)
      A_BRIGHT: bus.readdata = bright_next_q;
      A_BLINK:  bus.readdata = {28'd0, blink_en_q};
      A_HALF:   bus.readdata = {16'd0, blink_half_q};
      A_STATUS: bus.readdata = {8'd0, duty_q[7:0], pwm_cnt_q,
                                7'd0, phase_q};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q       <= 16'd0;
      pwm_cnt_q     <= 8'd0;
      bright_next_q <= 32'hFFFF_FFFF;
      duty_q        <= 32'hFFFF_FFFF;
      blink_en_q    <= 4'd0;
      blink_half_q  <= HALF_RST;
      frame_q       <= 16'd0;
      phase_q       <= 1'b1;
      led_out_q     <= 4'd0;
    end else begin
      presc_q       <= presc_d;
      pwm_cnt_q     <= pwm_cnt_d;
      bright_next_q <= bright_next_d;
      duty_q        <= duty_d;
      blink_en_q    <= blink_en_d;
      blink_half_q  <= blink_half_d;
      frame_q       <= frame_d;
      phase_q       <= phase_d;
      led_out_q     <= led_out_d;
    end
  end

  assign led_out = led_out_q;

endmodule

// File: tb/tb_led_pwm_driver.sv
// Directed bench for led_pwm_driver at PRESCALE=2:
// register table plus PWM, duty-update, blink and reset sequences.
module tb_led_pwm_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] led_in;
  logic [3:0] led_out;

  led_pwm_if bus ();

  led_pwm_driver #(.PRESCALE(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .led_in  (led_in),
    .led_out (led_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        wr;
    logic [1:0]  wa;
    logic [31:0] wd;
    logic [1:0]  ra;
    logic [31:0] mask;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    cyc();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.address = a;
    #1;
    d = bus.readdata;
  endtask

  task automatic wait_toggle(input int lim, output int n);
    logic p;
    p = led_out[0];
    n = 0;
    do begin
      cyc();
      n++;
    end while (led_out[0] == p && n < lim);
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] prev;
    int n, hi0, hi_oth;
    bit done;

    tbl[0] = '{1'b0, 2'd0, 32'h0, 2'd0, 32'hFFFF_FFFF,
               32'hFFFF_FFFF, "rst_bright"};
    tbl[1] = '{1'b0, 2'd0, 32'h0, 2'd1, 32'hFFFF_FFFF,
               32'h0, "rst_blink_en"};
    tbl[2] = '{1'b0, 2'd0, 32'h0, 2'd2, 32'hFFFF_FFFF,
               32'd100, "rst_blink_half"};
    tbl[3] = '{1'b1, 2'd1, 32'hFFFF_FFF5, 2'd1, 32'hFFFF_FFFF,
               32'h5, "blink_en_bits"};
    tbl[4] = '{1'b1, 2'd2, 32'hABCD_1234, 2'd2, 32'hFFFF_FFFF,
               32'h1234, "blink_half_bits"};
    tbl[5] = '{1'b1, 2'd0, 32'h1122_3344, 2'd0, 32'hFFFF_FFFF,
               32'h1122_3344, "bright_rw"};
    tbl[6] = '{1'b1, 2'd3, 32'hFFFF_FFFF, 2'd3, 32'hFFFF_00FF,
               32'h00FF_0001, "status_ro"};
    tbl[7] = '{1'b0, 2'd0, 32'h0, 2'd1, 32'hFFFF_FFFF,
               32'h5, "blink_en_keep"};

    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'd0;
    led_in         = 4'hF;

    // Reset and default readback
    reset = 1'b1;
    cyc();
    chk("rst_led_out", {28'd0, led_out}, 32'h0);
    cyc();
    reset = 1'b0;
    cyc();
    chk("led_full_on", {28'd0, led_out}, 32'hF);
    rd(2'd3, d);
    chk("rst_status", d, 32'h00FF_0001);

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].wr) wr(tbl[i].wa, tbl[i].wd);
      rd(tbl[i].ra, d);
      chk(tbl[i].name, d & tbl[i].mask, tbl[i].exp);
    end

    // 25% duty on channel 0, other channels at duty 0
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    led_in = 4'hF;
    wr(2'd0, 32'h0000_0040);
    bus.address = 2'd3;
    n = 0;
    done = 0;
    while (!done && n < 1200) begin
      rd(2'd3, d);
      if (d[23:16] != 8'hFF) done = 1;
      else begin
        cyc();
        n++;
      end
    end
    chk("pwm_load_timeout", {31'd0, done}, 32'd1);
    chk("pwm_duty_loaded", {24'd0, d[23:16]}, 32'h40);
    cyc();
    hi0 = 0;
    hi_oth = 0;
    for (int j = 0; j < 512; j++) begin
      if (led_out[0]) hi0++;
      if (led_out[3:1] != 3'd0) hi_oth++;
      cyc();
    end
    chk("pwm_ch0_high", hi0, 128);
    chk("pwm_ch123_off", hi_oth, 0);

    // Mid-frame write must wait for the frame end
    repeat (100) cyc();
    wr(2'd0, 32'h0000_00A0);
    rd(2'd3, d);
    chk("mid_duty_hold", {24'd0, d[23:16]}, 32'h40);
    prev = d;
    n = 0;
    done = 0;
    while (!done && n < 700) begin
      cyc();
      n++;
      rd(2'd3, d);
      if (d[23:16] != 8'h40) done = 1;
      else prev = d;
    end
    chk("mid_timeout", {31'd0, done}, 32'd1);
    chk("mid_duty_new", {24'd0, d[23:16]}, 32'hA0);
    chk("mid_cnt_wrap", {24'd0, d[15:8]}, 32'h0);
    chk("mid_cnt_prev", {24'd0, prev[15:8]}, 32'hFF);

    // Blink with half-period of 2 frames, then 0
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    led_in = 4'h1;
    wr(2'd2, 32'd2);
    wr(2'd1, 32'h1);
    wait_toggle(2100, n);
    chk("blink_sync", {31'd0, n < 2100}, 32'd1);
    wait_toggle(2100, n);
    chk("blink2_period_a", n, 1024);
    wait_toggle(2100, n);
    chk("blink2_period_b", n, 1024);
    wr(2'd2, 32'd0);
    wait_toggle(1100, n);
    chk("blink0_sync", {31'd0, n < 1100}, 32'd1);
    wait_toggle(1100, n);
    chk("blink0_period_a", n, 512);
    wait_toggle(1100, n);
    chk("blink0_period_b", n, 512);

    // Reset beats a simultaneous write and restarts counting
    repeat (37) cyc();
    reset = 1'b1;
    bus.address    = 2'd1;
    bus.writedata  = 32'hF;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    cyc();
    reset = 1'b0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    rd(2'd1, d);
    chk("rst_wr_blink_en", d, 32'h0);
    rd(2'd2, d);
    chk("rst_wr_half", d, 32'd100);
    rd(2'd3, d);
    chk("rst_cnt_0", {24'd0, d[15:8]}, 32'h0);
    chk("rst_phase", {31'd0, d[0]}, 32'h1);
    cyc();
    rd(2'd3, d);
    chk("rst_cnt_1st", {24'd0, d[15:8]}, 32'h0);
    cyc();
    rd(2'd3, d);
    chk("rst_cnt_step", {24'd0, d[15:8]}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_pwm_driver.md
LED_PWM_DRIVER -- requirements
Module: led_pwm_driver

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 50: clk cycles per PWM tick, legal range 1..65535.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL be updated on its rising edge.
REQ-003 Port reset, input, 1 bit: reset is synchronous and active-high.
REQ-004 Port address, input, 2 bits: Avalon-MM register select.
REQ-005 Port chipselect, input, 1 bit: Avalon-MM slave select.
REQ-006 Port write_n, input, 1 bit: active-low write strobe.
REQ-007 Port writedata, input, 32 bits: write data.
REQ-008 Port readdata, output, 32 bits: combinational read data, zero wait states.
REQ-009 Port led_in, input, 4 bits: per-LED on request, driven by the LED PIO out_port.
REQ-010 Port led_out, output, 4 bits: registered drive to the board LEDs.

Function
REQ-011 A write SHALL occur on a cycle with chipselect=1 and write_n=0.
REQ-012 Address 0 SHALL be BRIGHT_NEXT: the four 8-bit duty values, with channel i in bits [8i+7:8i].
REQ-013 Address 1 SHALL be BLINK_EN: bits [3:0] are per-channel blink enables; bits [31:4] are written as ignored and read as 0.
REQ-014 Address 2 SHALL be BLINK_HALF: bits [15:0] give the blink half-period in PWM frames; bits [31:16] read as 0.
REQ-015 Address 3 SHALL be STATUS, read-only with writes ignored: bit0 = blink phase, bits [15:8] = pwm_cnt, bits [23:16] = channel-0 active duty, all other bits 0.
REQ-016 readdata SHALL reflect the addressed register in the same cycle as address changes; it does not depend on chipselect.
REQ-017 The prescaler SHALL count 0..PRESCALE-1 and assert a one-cycle tick when the count equals PRESCALE-1, then wrap to 0.
REQ-018 pwm_cnt (8 bits) SHALL increment on each tick and wrap 255->0; the tick that wraps it is the frame end.
REQ-019 Active duty registers SHALL load from BRIGHT_NEXT only at frame end, so PWM is glitch-free.
- A write on the frame-end cycle is not captured until the next frame end.
REQ-020 The PWM on-condition for channel i SHALL be: duty=255 gives always on; otherwise pwm_cnt < duty. Duty=0 is therefore always off.
REQ-021 The frame counter (16 bits) SHALL increment at each frame end.
- When it is >= max(BLINK_HALF,1)-1 at a frame end, phase toggles and the counter clears.
- If BLINK_HALF is written below the current count, the toggle occurs at the next frame end.
REQ-022 led_out[i] SHALL be registered as led_in[i] AND pwm_on[i] AND (NOT blink_en[i] OR phase), giving 1 cycle of latency from inputs to pin.
REQ-023 A BLINK_EN write SHALL take effect on the next cycle, without waiting for a frame end.
REQ-024 With PRESCALE=1, a tick SHALL occur every cycle.

Reset
REQ-025 While reset=1 at a clock edge, the block SHALL load the following values, overriding any simultaneous write:
- prescaler = 0, pwm_cnt = 0, frame counter = 0;
- BRIGHT_NEXT = active duty = 0xFFFFFFFF;
- BLINK_EN = 0;
- BLINK_HALF = 100;
- phase = 1;
- led_out = 0.
REQ-026 After reset deasserts, led_out SHALL equal the registered led_in one cycle later, i.e. full brightness with no blink.
REQ-027 Reset asserted mid-frame SHALL abandon that frame; counting restarts from 0 on the first cycle after deassertion.

Verification
REQ-028 The bench SHALL cover these directed scenarios, with PRESCALE=2:
- Reset, then led_in=4'hF -> led_out=4'hF from the next cycle; readdata at address 0 = 0xFFFFFFFF; address 2 = 100; address 3 = 0x00FF0001.
- Write BRIGHT=0x00000040, led_in=1 -> after the next frame end, led_out[0] is high 128 cycles per 512-cycle frame; channels 1..3 are off.
- Write BRIGHT mid-frame -> the duty shown in STATUS[23:16] is unchanged until the frame-end cycle, then updates.
- BLINK_HALF=2, BLINK_EN=1, BRIGHT=0xFFFFFFFF, led_in=1 -> led_out[0] toggles every 1024 cycles; BLINK_HALF=0 gives a toggle every frame (512 cycles).
- Assert reset for one cycle concurrent with a write of address 1 = 0xF -> BLINK_EN reads 0; pwm_cnt reads 0 on the first cycle after reset.
- Write address 3 = 0xFFFFFFFF -> STATUS is unchanged; register readback at addresses 1 and 2 shows only the defined bits.
